// File: rtl/fnd_scan_decoder.sv
//------------------------------------------------------------------------------
// Module      : fnd_scan_decoder
// Description : Rebuilds the four BCD digits shown on a multiplexed, active-low
//               7-segment bus. A (digit, segment) pair is captured once it has
//               held for P_SETTLE cycles. A 16-bit word is published once every
//               digit slot has been captured. Undecodable patterns are flagged,
//               and a stale flag is raised when no frame completes in time.
//               Optional macro FND_DECODE_HEX_EN adds decoding of A..F.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fnd_scan_decoder #(
  parameter int P_SETTLE  = 4,
  parameter int P_TIMEOUT = 65535
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [3:0]  i_Digit,
  input  logic [6:0]  i_FND,
  output logic [15:0] o_Value,
  output logic [3:0]  o_Blank,
  output logic        o_Valid,
  output logic        o_Err,
  output logic        o_Stale
);

  localparam logic [1:0]  c_ST_WAIT  = 2'd0;
  localparam logic [1:0]  c_ST_CAPT  = 2'd1;
  localparam logic [1:0]  c_ST_PUBL  = 2'd2;
  localparam logic [1:0]  c_ST_HOLD  = 2'd3;
  localparam logic [7:0]  c_SETTLE   = 8'(P_SETTLE);
  localparam logic [19:0] c_TIMEOUT  = 20'(P_TIMEOUT);

  logic [3:0]  r_Digit;
  logic [6:0]  r_FND;
  logic [7:0]  r_Settle;
  logic        r_Armed;     // current pair has not been captured yet
  logic [1:0]  r_State;
  logic [15:0] r_SlotNib;
  logic [3:0]  r_SlotBlank;
  logic [3:0]  r_SlotInv;
  logic [3:0]  r_Seen;
  logic [19:0] r_Tmo;

  logic        w_Chg;
  logic        w_Legal;
  logic [1:0]  w_Idx;
  logic [3:0]  w_Sel;
  logic [3:0]  w_Nib;
  logic        w_Blank;
  logic        w_Inv;
  logic        w_SettleHit;
  logic [3:0]  w_SeenNext;

  // The incoming pair differs from the registered copy: the registered pair
  // changes on this edge.
  assign w_Chg = ({i_Digit, i_FND} != {r_Digit, r_FND});

  // Decode the one-cold digit select into a slot index.
  always_comb begin
    w_Legal = 1'b1;
    w_Idx   = 2'd0;
    w_Sel   = 4'b0000;
    case (r_Digit)
      4'b1110: begin w_Idx = 2'd0; w_Sel = 4'b0001; end
      4'b1101: begin w_Idx = 2'd1; w_Sel = 4'b0010; end
      4'b1011: begin w_Idx = 2'd2; w_Sel = 4'b0100; end
      4'b0111: begin w_Idx = 2'd3; w_Sel = 4'b1000; end
      default: w_Legal = 1'b0;
    endcase
  end

  // Decode the active-low {g..a} segment pattern into a nibble.
  always_comb begin
    w_Nib   = 4'h0;
    w_Blank = 1'b0;
    w_Inv   = 1'b0;
    case (r_FND)
      7'b1000000: w_Nib = 4'h0;
      7'b1111001: w_Nib = 4'h1;
      7'b0100100: w_Nib = 4'h2;
      7'b0110000: w_Nib = 4'h3;
      7'b0011001: w_Nib = 4'h4;
      7'b0010010: w_Nib = 4'h5;
      7'b0000010: w_Nib = 4'h6;
      7'b1111000: w_Nib = 4'h7;
      7'b0000000: w_Nib = 4'h8;
      7'b0010000: w_Nib = 4'h9;
      7'b1111111: w_Blank = 1'b1;
`ifdef FND_DECODE_HEX_EN
      7'b0001000: w_Nib = 4'hA;
      7'b0000011: w_Nib = 4'hB;
      7'b1000110: w_Nib = 4'hC;
      7'b0100001: w_Nib = 4'hD;
      7'b0000110: w_Nib = 4'hE;
      7'b0001110: w_Nib = 4'hF;
`endif
      default:    w_Inv = 1'b1;
    endcase
  end

  // Settle completes on the edge where the count would reach P_SETTLE; the
  // >= also covers a count that saturated while the FSM was busy publishing.
  assign w_SettleHit = r_Armed && !w_Chg && w_Legal &&
                       (r_Settle >= (c_SETTLE - 8'd1));
  assign w_SeenNext  = r_Seen | w_Sel;
  assign o_Stale     = (r_Tmo == c_TIMEOUT);

  // Input register, settle counter and capture-pending flag.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Digit  <= 4'hF;
      r_FND    <= 7'h7F;
      r_Settle <= 8'd0;
      r_Armed  <= 1'b0;
    end else begin
      r_Digit <= i_Digit;
      r_FND   <= i_FND;
      if (w_Chg || !w_Legal) begin
        r_Settle <= 8'd0;
      end else if (r_Settle < c_SETTLE) begin
        r_Settle <= r_Settle + 8'd1;
      end
      if (w_Chg) begin
        r_Armed <= 1'b1;
      end else if (r_State == c_ST_WAIT && w_SettleHit) begin
        r_Armed <= 1'b0;
      end
    end
  end

  // Capture / publish state machine with slot storage and outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= c_ST_WAIT;
      r_SlotNib   <= 16'h0000;
      r_SlotBlank <= 4'hF;
      r_SlotInv   <= 4'h0;
      r_Seen      <= 4'h0;
      o_Value     <= 16'h0000;
      o_Blank     <= 4'hF;
      o_Valid     <= 1'b0;
      o_Err       <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      case (r_State)
        c_ST_WAIT: begin
          if (w_SettleHit) begin
            r_State <= c_ST_CAPT;
          end
        end
        c_ST_CAPT: begin
          // The registered pair cannot change until the edge leaving CAPT,
          // so it is still the pair that settled.
          if (w_Legal) begin
            r_SlotNib[{w_Idx, 2'b00} +: 4] <= w_Nib;
            r_SlotBlank[w_Idx]             <= w_Blank;
            r_SlotInv[w_Idx]               <= w_Inv;
            r_Seen                         <= w_SeenNext;
          end
          r_State <= (w_Legal && (&w_SeenNext)) ? c_ST_PUBL : c_ST_HOLD;
        end
        c_ST_PUBL: begin
          o_Value <= r_SlotNib;
          o_Blank <= r_SlotBlank;
          o_Err   <= |r_SlotInv;
          o_Valid <= 1'b1;
          r_Seen  <= 4'h0;
          r_State <= c_ST_HOLD;
        end
        default: begin
          // Leave once a new pair has been seen, even if it arrived while
          // the FSM was in CAPT or PUBL.
          if (r_Armed || w_Chg) begin
            r_State <= c_ST_WAIT;
          end
        end
      endcase
    end
  end

  // Frame timeout counter; cleared by the publish that pulses o_Valid.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Tmo <= 20'd0;
    end else if (r_State == c_ST_PUBL) begin
      r_Tmo <= 20'd0;
    end else if (r_Tmo != c_TIMEOUT) begin
      r_Tmo <= r_Tmo + 20'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_fnd_scan_decoder
// Description : Scoreboard bench for fnd_scan_decoder. Stimulus pushes the
//               expected frame (value, blank, error, arrival cycle). A monitor
//               pops an entry on every o_Valid pulse and compares it.
//               Honours FND_DECODE_HEX_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fnd_scan_decoder;

  localparam int P_SETTLE  = 4;
  localparam int P_TIMEOUT = 200;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [3:0]  i_Digit;
  logic [6:0]  i_FND;
  logic [15:0] o_Value;
  logic [3:0]  o_Blank;
  logic        o_Valid;
  logic        o_Err;
  logic        o_Stale;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  b;
    logic        e;
    int          t;
  } exp_s;

  exp_s sb[$];
  exp_s m_exp;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_valid = 0;
  int   cyc     = 0;

  fnd_scan_decoder #(.P_SETTLE(P_SETTLE), .P_TIMEOUT(P_TIMEOUT)) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Digit (i_Digit),
    .i_FND   (i_FND),
    .o_Value (o_Value),
    .o_Blank (o_Blank),
    .o_Valid (o_Valid),
    .o_Err   (o_Err),
    .o_Stale (o_Stale)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] sel(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [3:0] d, input logic [6:0] f, input int n);
    i_Digit = d;
    i_FND   = f;
    repeat (n) @(negedge i_Clk);
  endtask

  // Called just before the pair that completes a frame is driven.
  task automatic expect_frame(input logic [15:0] v, input logic [3:0] b, input logic e);
    exp_s x;
    x.v = v; x.b = b; x.e = e; x.t = cyc + P_SETTLE + 3;
    sb.push_back(x);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge i_Clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d frames outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_value", 32'(o_Value), 32'h0);
    chk("rst_blank", 32'(o_Blank), 32'hF);
    chk("rst_valid", 32'(o_Valid), 32'h0);
    chk("rst_err",   32'(o_Err),   32'h0);
    chk("rst_stale", 32'(o_Stale), 32'h0);
  endtask

  // Monitor: every o_Valid pulse must match the oldest expected frame.
  always @(negedge i_Clk) begin
    if (o_Valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got pulse with o_Value=%h, required no pulse", o_Value);
      end else begin
        m_exp = sb.pop_front();
        chk("frame_value",   32'(o_Value), 32'(m_exp.v));
        chk("frame_blank",   32'(o_Blank), 32'(m_exp.b));
        chk("frame_err",     32'(o_Err),   32'(m_exp.e));
        chk("frame_latency", 32'(cyc),     32'(m_exp.t));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst   = 1'b1;
    i_Digit = 4'hF;
    i_FND   = 7'h7F;
    repeat (3) @(negedge i_Clk);
    chk_reset_state();
    i_Rst = 1'b0;

    // "1234" twice: digit0=4 .. digit3=1
    for (int f = 0; f < 2; f++) begin
      put(sel(0), seg(4), 8);
      put(sel(1), seg(3), 8);
      put(sel(2), seg(2), 8);
      expect_frame(16'h1234, 4'b0000, 1'b0);
      put(sel(3), seg(1), 8);
    end
    drain();
    chk("valid_count_1234", 32'(n_valid), 32'd2);
    chk("stale_after_frame", 32'(o_Stale), 32'h0);

    // Digits held too briefly: nothing captured, timeout expires.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 4; k++) begin
        put(sel(k), seg(k + 1), P_SETTLE - 1);
      end
    end
    chk("short_no_valid", 32'(n_valid), 32'd2);
    chk("short_value_held", 32'(o_Value), 32'h1234);
    chk("stale_set", 32'(o_Stale), 32'h1);

    // digit3..0 = 0, blank, 5, 9
    put(sel(0), seg(9), 8);
    put(sel(1), seg(5), 8);
    put(sel(2), 7'h7F, 8);
    expect_frame(16'h0059, 4'b0100, 1'b0);
    put(sel(3), seg(0), 8);
    drain();
    chk("stale_cleared", 32'(o_Stale), 32'h0);

    // Pattern 0001000 on digit 1
    put(sel(0), seg(3), 8);
    put(sel(1), 7'b0001000, 8);
    put(sel(2), seg(2), 8);
`ifdef FND_DECODE_HEX_EN
    expect_frame(16'h12A3, 4'b0000, 1'b0);
`else
    expect_frame(16'h1203, 4'b0000, 1'b1);
`endif
    put(sel(3), seg(1), 8);
    drain();

    // "0007" with illegal selects in between
    put(sel(0), seg(7), 8);
    put(4'b1100, seg(7), 8);
    put(4'b1111, seg(3), 8);
    put(sel(1), seg(0), 8);
    put(4'b1100, seg(0), 8);
    put(sel(2), seg(0), 8);
    put(4'b1111, seg(0), 8);
    expect_frame(16'h0007, 4'b0000, 1'b0);
    put(sel(3), seg(0), 8);
    drain();

    // Reset after two captures discards the partial frame.
    put(sel(0), seg(8), 8);
    put(sel(1), seg(7), 8);
    i_Rst   = 1'b1;
    i_Digit = 4'hF;
    i_FND   = 7'h7F;
    repeat (2) @(negedge i_Clk);
    chk_reset_state();
    i_Rst = 1'b0;
    put(sel(2), seg(6), 8);
    put(sel(3), seg(5), 8);
    put(sel(0), seg(8), 8);
    expect_frame(16'h5678, 4'b0000, 1'b0);
    put(sel(1), seg(7), 8);
    drain();
    chk("valid_count_total", 32'(n_valid), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
